// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg
// Shared definitions for the round-robin multiplier arbiter: pipeline latency,
// performance counter width, the requester ID width helper and the tag that
// travels alongside each operation through the multiplier pipeline.
// Optional feature macro used by the arbiter: MULT_ARB_PERF_CNT_EN.
package mult_arb_pkg;

   localparam int MULT_LATENCY = 2;
   localparam int PERF_CNT_W   = 32;

   // Tags are sized for the largest supported requester count (8) so the
   // struct can live in a package without depending on a module parameter.
   localparam int TAG_ID_W     = 3;

   // Number of bits needed to name one of n requesters, never below one.
   function automatic int id_width(input int n);
      if (n <= 2) begin
         return 1;
      end
      return $clog2(n);
   endfunction

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/pipelined_multiplier_2stage.sv
// pipelined_multiplier_2stage
// Two-stage signed multiplier. Stage 1 registers the operands, stage 2
// registers the full-precision product. The product register only loads when
// a valid operation reaches it, so it holds the last result while idle.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_valid, i_a, i_b     operation valid and signed operands
//   o_valid, o_product    product valid and signed 2*INPUT_WIDTH product
module pipelined_multiplier_2stage
   import mult_arb_pkg::*;
#(
   parameter int INPUT_WIDTH = 18
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_valid,
   input  logic [INPUT_WIDTH-1:0]   i_a,
   input  logic [INPUT_WIDTH-1:0]   i_b,
   output logic                     o_valid,
   output logic [2*INPUT_WIDTH-1:0] o_product
);

   logic [INPUT_WIDTH-1:0]   a_q;
   logic [INPUT_WIDTH-1:0]   b_q;
   logic                     s1_valid_q;
   logic [2*INPUT_WIDTH-1:0] product_q;
   logic                     s2_valid_q;
   logic [2*INPUT_WIDTH-1:0] a_ext;
   logic [2*INPUT_WIDTH-1:0] b_ext;

   // Sign-extending both operands to the product width makes the low
   // 2*INPUT_WIDTH bits of an unsigned multiply equal the signed product.
   assign a_ext = {{INPUT_WIDTH{a_q[INPUT_WIDTH-1]}}, a_q};
   assign b_ext = {{INPUT_WIDTH{b_q[INPUT_WIDTH-1]}}, b_q};

   // Stage 1 captures operands, stage 2 captures the product. Reset drops
   // both valids so any in-flight work is discarded.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         a_q        <= '0;
         b_q        <= '0;
         s1_valid_q <= 1'b0;
         product_q  <= '0;
         s2_valid_q <= 1'b0;
      end else begin
         a_q        <= i_a;
         b_q        <= i_b;
         s1_valid_q <= i_valid;
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            product_q <= a_ext * b_ext;
         end
      end
   end

   assign o_valid   = s2_valid_q;
   assign o_product = product_q;

endmodule

// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter
// Shares one two-stage pipelined signed multiplier among NUM_REQ requesters.
// A round-robin search starting at rr_ptr grants at most one request per
// cycle, the granted operands go straight into the multiplier, and a tag pipe
// carrying the requester ID runs alongside so the product is steered back to
// its originator two cycles after acceptance.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_req_valid         per-requester request valid
//   i_req_a, i_req_b    packed signed operands, requester k at slice k
//   o_req_ready         one-hot combinational grant
//   o_rsp_valid         one-hot product valid
//   o_rsp_data          product shared by all requesters
//   o_busy              an operation is in flight
//   o_grant_cnt         per-requester saturating accept counters, only
//                       present when MULT_ARB_PERF_CNT_EN is defined
module mult_rr_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int INPUT_WIDTH = 18
) (
   input  logic                             i_clk,
   input  logic                             i_reset,
   input  logic [NUM_REQ-1:0]               i_req_valid,
   input  logic [NUM_REQ*INPUT_WIDTH-1:0]   i_req_a,
   input  logic [NUM_REQ*INPUT_WIDTH-1:0]   i_req_b,
   output logic [NUM_REQ-1:0]               o_req_ready,
   output logic [NUM_REQ-1:0]               o_rsp_valid,
   output logic [2*INPUT_WIDTH-1:0]         o_rsp_data,
`ifdef MULT_ARB_PERF_CNT_EN
   output logic [NUM_REQ*PERF_CNT_W-1:0]    o_grant_cnt,
`endif
   output logic                             o_busy
);

   localparam int IDW = id_width(NUM_REQ);
   localparam int PW  = 2*INPUT_WIDTH;

   logic [IDW-1:0]         rr_ptr_q;
   logic [IDW-1:0]         rr_ptr_d;
   logic [NUM_REQ-1:0]     grant;
   logic                   grant_found;
   logic [IDW-1:0]         grant_id;
   logic [INPUT_WIDTH-1:0] mul_a;
   logic [INPUT_WIDTH-1:0] mul_b;
   logic                   mul_valid_out;
   logic [PW-1:0]          mul_product;
   tag_t                   tag_d;
   tag_t                   tag_q [MULT_LATENCY];
   logic                   busy_d;
   logic                   busy_q;

   // Round-robin search: offset i from rr_ptr names candidate (rr_ptr+i) mod
   // NUM_REQ, and the first valid candidate wins. The inner loop uses only
   // constant indices so the selection stays a clean priority mux. Reset
   // forces every grant low.
   always_comb begin
      grant       = '0;
      grant_found = 1'b0;
      grant_id    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && i_req_valid[k] &&
                (k == ((int'(rr_ptr_q) + i) % NUM_REQ))) begin
               grant_found = 1'b1;
               grant[k]    = 1'b1;
               grant_id    = IDW'(k);
            end
         end
      end
      if (i_reset) begin
         grant       = '0;
         grant_found = 1'b0;
         grant_id    = '0;
      end
   end

   // Operand mux: the one-hot grant selects which requester's operands feed
   // the multiplier; with no grant the operands are zero and unused.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) begin
            mul_a = i_req_a[k*INPUT_WIDTH +: INPUT_WIDTH];
            mul_b = i_req_b[k*INPUT_WIDTH +: INPUT_WIDTH];
         end
      end
   end

   // Next pointer sits just past the winner so it becomes lowest priority,
   // which bounds any waiting requester to NUM_REQ cycles. No grant, no move.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_found) begin
         if (int'(grant_id) == NUM_REQ-1) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = grant_id + IDW'(1);
         end
      end
   end

   // Tag entering the pipe this cycle, plus the next-cycle busy flag: busy
   // next cycle exactly when some tag stage will hold a valid entry.
   always_comb begin
      tag_d.valid = grant_found;
      tag_d.id    = TAG_ID_W'(grant_id);
      busy_d      = tag_d.valid;
      for (int i = 0; i < MULT_LATENCY-1; i++) begin
         busy_d = busy_d | tag_q[i].valid;
      end
   end

   // Pointer, tag pipe and busy registers. The tag pipe shifts every cycle
   // in lockstep with the multiplier valids; reset empties it so products
   // already in flight never produce a response.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rr_ptr_q <= '0;
         busy_q   <= 1'b0;
         for (int i = 0; i < MULT_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         busy_q   <= busy_d;
         tag_q[0] <= tag_d;
         for (int i = 1; i < MULT_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   pipelined_multiplier_2stage #(
      .INPUT_WIDTH(INPUT_WIDTH)
   ) u_mult (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_valid  (grant_found),
      .i_a      (mul_a),
      .i_b      (mul_b),
      .o_valid  (mul_valid_out),
      .o_product(mul_product)
   );

   // Response demux: a pure decode of the last tag stage and the multiplier
   // output valid, both flops, so the one-hot valid is glitch-free and lines
   // up with the registered product.
   always_comb begin
      o_rsp_valid = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         o_rsp_valid[k] = mul_valid_out && tag_q[MULT_LATENCY-1].valid &&
                          (tag_q[MULT_LATENCY-1].id == TAG_ID_W'(k));
      end
   end

   assign o_req_ready = grant;
   assign o_rsp_data  = mul_product;
   assign o_busy      = busy_q;

`ifdef MULT_ARB_PERF_CNT_EN
   logic [NUM_REQ-1:0][PERF_CNT_W-1:0] grant_cnt_q;

   // One saturating counter per requester, bumped on each accepted handshake
   // and pinned at all-ones once it gets there.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         grant_cnt_q <= '0;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k] && (grant_cnt_q[k] != '1)) begin
               grant_cnt_q[k] <= grant_cnt_q[k] + PERF_CNT_W'(1);
            end
         end
      end
   end

   assign o_grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// tb_mult_rr_arbiter
// Self-checking bench for mult_rr_arbiter (NUM_REQ=4, INPUT_WIDTH=18).
// A negedge monitor pushes the expected product of every accepted handshake
// into a queue and pops it when a response appears; scenario tasks check
// grants and registered outputs inline. Counter tests build only when
// MULT_ARB_PERF_CNT_EN is defined.
module tb_mult_rr_arbiter;

   localparam int NUM_REQ = 4;
   localparam int W       = 18;
   localparam int PW      = 2*W;

   typedef struct {
      logic [NUM_REQ-1:0] onehot;
      logic [PW-1:0]      data;
      int                 cyc;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ*W-1:0]   req_a;
   logic [NUM_REQ*W-1:0]   req_b;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ-1:0]     rsp_valid;
   logic [PW-1:0]          rsp_data;
   logic                   busy;
`ifdef MULT_ARB_PERF_CNT_EN
   logic [NUM_REQ*32-1:0]  grant_cnt;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sbq[$];

   always #5 clk = ~clk;

   // Free-running cycle count used to verify the fixed response latency.
   always @(posedge clk) cyc <= cyc + 1;

   mult_rr_arbiter #(
      .NUM_REQ(NUM_REQ),
      .INPUT_WIDTH(W)
   ) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_req_valid(req_valid),
      .i_req_a    (req_a),
      .i_req_b    (req_b),
      .o_req_ready(req_ready),
      .o_rsp_valid(rsp_valid),
      .o_rsp_data (rsp_data),
`ifdef MULT_ARB_PERF_CNT_EN
      .o_grant_cnt(grant_cnt),
`endif
      .o_busy     (busy)
   );

   // Scoreboard monitor: responses are compared before this cycle's
   // handshakes are recorded, a reset cycle discards everything in flight.
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid !== '0) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("[TB] FAIL rsp_unexpected: got valid=%b data=%h, expected no response", rsp_valid, rsp_data);
         end else begin
            e = sbq.pop_front();
            if (rsp_valid !== e.onehot || rsp_data !== e.data || cyc != e.cyc + 2) begin
               errors++;
               $display("[TB] FAIL rsp_scoreboard: got valid=%b data=%h cycle=%0d, expected valid=%b data=%h cycle=%0d",
                        rsp_valid, rsp_data, cyc, e.onehot, e.data, e.cyc + 2);
            end
         end
      end
      if (rst) begin
         sbq.delete();
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid[k] && req_ready[k]) begin
               logic signed [W-1:0] a;
               logic signed [W-1:0] b;
               longint              p;
               a = req_a[k*W +: W];
               b = req_b[k*W +: W];
               p = longint'(a) * longint'(b);
               e.onehot = NUM_REQ'(1) << k;
               e.data   = p[PW-1:0];
               e.cyc    = cyc;
               sbq.push_back(e);
            end
         end
      end
   end

   task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[k*W +: W] = a;
      req_b[k*W +: W] = b;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = '1;
      for (int k = 0; k < NUM_REQ; k++) set_op(k, W'(k + 1), W'(k + 2));
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (req_ready !== '0) begin
         errors++;
         $display("[TB] FAIL reset_ready: got %b, expected 0000", req_ready);
      end
      checks++;
      if (rsp_valid !== '0 || busy !== 1'b0 || rsp_data !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got valid=%b busy=%b data=%h, expected 0/0/0", rsp_valid, busy, rsp_data);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      req_valid = '0;
   endtask

   task automatic test_single();
      logic [PW-1:0] exp_p;
      exp_p = PW'(-15);
      apply_reset();
      @(posedge clk);
      #1 set_op(2, W'(3), W'(-5));
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL single_ready: got %b, expected 0100", req_ready);
      end
      @(posedge clk);
      #1 req_valid = '0;
      #1;
      checks++;
      if (busy !== 1'b1 || rsp_valid !== '0) begin
         errors++;
         $display("[TB] FAIL single_t1: got busy=%b valid=%b, expected busy=1 valid=0000", busy, rsp_valid);
      end
      @(posedge clk);
      #2;
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_data !== exp_p || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_rsp: got valid=%b data=%h busy=%b, expected valid=0100 data=%h busy=1", rsp_valid, rsp_data, busy, exp_p);
      end
      @(posedge clk);
      #2;
      checks++;
      if (rsp_valid !== '0 || rsp_data !== exp_p || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_hold: got valid=%b data=%h busy=%b, expected valid=0000 data=%h busy=0", rsp_valid, rsp_data, busy, exp_p);
      end
   endtask

   task automatic test_round_robin();
      logic [NUM_REQ-1:0] exp_g;
      apply_reset();
      @(posedge clk);
      #1;
      for (int k = 0; k < NUM_REQ; k++) set_op(k, W'($urandom), W'($urandom));
      req_valid = '1;
      for (int i = 0; i < 8; i++) begin
         exp_g = NUM_REQ'(1) << (i % NUM_REQ);
         #1;
         checks++;
         if (req_ready !== exp_g) begin
            errors++;
            $display("[TB] FAIL rr_order[%0d]: got %b, expected %b", i, req_ready, exp_g);
         end
         @(posedge clk);
         #1 set_op(i % NUM_REQ, W'($urandom), W'($urandom));
      end
      req_valid = '0;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_rr_ptr();
      apply_reset();
      @(posedge clk);
      #1 set_op(1, W'(11), W'(-7));
      req_valid = 4'b0010;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL ptr_setup: got %b, expected 0010", req_ready);
      end
      @(posedge clk);
      #1 set_op(0, W'(-100), W'(25));
      set_op(3, W'(1234), W'(-4321));
      req_valid = 4'b1001;
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL ptr_wrap_first: got %b, expected 1000", req_ready);
      end
      @(posedge clk);
      #1 req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL ptr_wrap_second: got %b, expected 0001", req_ready);
      end
      @(posedge clk);
      #1 req_valid = '0;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_extremes();
      logic [PW-1:0] exp1;
      logic [PW-1:0] exp2;
      exp1 = PW'(64'sd17179869184);
      exp2 = PW'(-64'sd17179738112);
      apply_reset();
      @(posedge clk);
      #1 set_op(0, W'(-131072), W'(-131072));
      req_valid = 4'b0001;
      @(posedge clk);
      #1 set_op(1, W'(131071), W'(-131072));
      req_valid = 4'b0010;
      @(posedge clk);
      #1 req_valid = '0;
      #1;
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_data !== exp1) begin
         errors++;
         $display("[TB] FAIL extreme_neg_neg: got valid=%b data=%h, expected valid=0001 data=%h", rsp_valid, rsp_data, exp1);
      end
      @(posedge clk);
      #2;
      checks++;
      if (rsp_valid !== 4'b0010 || rsp_data !== exp2) begin
         errors++;
         $display("[TB] FAIL extreme_pos_neg: got valid=%b data=%h, expected valid=0010 data=%h", rsp_valid, rsp_data, exp2);
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_back_to_back();
      @(posedge clk);
      #1 req_valid = 4'b1000;
      for (int i = 0; i < 6; i++) begin
         set_op(3, W'($urandom), W'($urandom));
         #1;
         checks++;
         if (req_ready !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL sole_grant[%0d]: got %b, expected 1000", i, req_ready);
         end
         @(posedge clk);
         #1;
      end
      req_valid = '0;
      #1;
      checks++;
      if (rsp_valid !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL sole_stream: got valid=%b, expected 1000", rsp_valid);
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_reset_mid();
      apply_reset();
      @(posedge clk);
      #1 set_op(0, W'(7), W'(9));
      req_valid = 4'b0001;
      @(posedge clk);
      #1 set_op(1, W'(-8), W'(6));
      req_valid = 4'b0010;
      @(posedge clk);
      #1 rst = 1'b1;
      req_valid = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_after: got valid=%b busy=%b, expected 0000/0", rsp_valid, busy);
      end
      @(posedge clk);
      #2;
      checks++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_later: got valid=%b busy=%b, expected 0000/0", rsp_valid, busy);
      end
   endtask

`ifdef MULT_ARB_PERF_CNT_EN
   task automatic test_perf_cnt();
      apply_reset();
      @(posedge clk);
      #1 set_op(1, W'(2), W'(3));
      req_valid = 4'b0010;
      repeat (5) @(posedge clk);
      #1 req_valid = '0;
      #1;
      checks++;
      if (grant_cnt[63:32] !== 32'd5) begin
         errors++;
         $display("[TB] FAIL perf_count: got %0d, expected 5", grant_cnt[63:32]);
      end
      force dut.grant_cnt_q[1] = 32'hFFFF_FFFE;
      @(posedge clk);
      #1 release dut.grant_cnt_q[1];
      req_valid = 4'b0010;
      repeat (3) @(posedge clk);
      #1 req_valid = '0;
      #1;
      checks++;
      if (grant_cnt[63:32] !== 32'hFFFF_FFFF) begin
         errors++;
         $display("[TB] FAIL perf_saturate: got %h, expected ffffffff", grant_cnt[63:32]);
      end
      repeat (3) @(posedge clk);
   endtask
`endif

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_rr_ptr();
      test_extremes();
      test_back_to_back();
      test_reset_mid();
`ifdef MULT_ARB_PERF_CNT_EN
      test_perf_cnt();
`endif
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("[TB] FAIL rsp_missing: got %0d outstanding, expected 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_rr_arbiter.md
# mult_rr_arbiter

Round-robin arbiter that shares one two-stage pipelined signed multiplier among NUM_REQ requesters in the bicubic upscaler datapath, e.g. per-tap coefficient multiplies from parallel row engines. It grants at most one request per cycle and issues the operands to the internal multiplier. It tags each issued operation with its requester ID and routes the product back to the originating requester after the fixed pipeline latency. Throughput is one product per cycle aggregate, and no requester is starved.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- INPUT_WIDTH, 18, operand width, even; product is 2*INPUT_WIDTH
- i_clk  in  1  clock
- i_reset  in  1  reset; synchronous, active-high; clock i_clk
- i_req_valid  in  NUM_REQ  per-requester request valid
- i_req_a  in  NUM_REQ*INPUT_WIDTH  signed operand A, requester k at slice k
- i_req_b  in  NUM_REQ*INPUT_WIDTH  signed operand B, same packing
- o_req_ready  out  NUM_REQ  one-hot grant (combinational), 0 in reset
- o_rsp_valid  out  NUM_REQ  one-hot product-valid, registered, 0 in reset
- o_rsp_data  out  2*INPUT_WIDTH  signed product shared by all requesters, qualified by o_rsp_valid, 0 in reset
- o_busy  out  1  any operation in flight, registered, 0 in reset

## Operation
- Handshake: transfer on i_req_valid[k] && o_req_ready[k]. A requester holds valid and operands stable until ready. Valid must not be dropped before acceptance.
- Grant: search starts at rr_ptr and wraps modulo NUM_REQ. The first valid index gets ready. At most one ready bit is high. All ready bits are 0 when no valid is asserted or i_reset is high.
- rr_ptr: resets to 0. On grant to k, becomes (k+1) mod NUM_REQ next cycle. It is unchanged with no grant.
- Issue: the granted operands and mul_valid=1 drive the multiplier in the same cycle. The multiplier never back-pressures, so issue always succeeds.
- Tag pipe: 2-stage shift register of {valid, ID[$clog2(NUM_REQ)-1:0]}, advancing every cycle. It is aligned with the multiplier's valid pipeline.
- Response: when the multiplier output valid is high, o_rsp_valid[tag ID]=1 and o_rsp_data=product. The responder has no ready and must sink the product.
- o_rsp_data holds the last product when idle. No new value appears without o_rsp_valid.
- o_busy=1 while any tag-pipe stage is valid.
- Arithmetic: full-precision signed product, no rounding or saturation. Example: (-2^17)*(-2^17) = 2^34.
- Reset mid-operation: in-flight tags and multiplier valids are cleared, and those products are discarded with no o_rsp_valid. rr_ptr returns to 0.

## Timing
- Request accepted at cycle t gives o_rsp_valid at cycle t+2 (registered). Latency is fixed at 2.
- Back-to-back grants every cycle give o_rsp_valid every cycle, in grant order.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- Sole requester: granted every cycle.
- Simultaneous grant and response for the same requester in one cycle is legal.

## Configuration
- MULT_ARB_PERF_CNT_EN defined:
  - Adds port o_grant_cnt, out, NUM_REQ*32. It holds one 32-bit saturating accepted-request counter per requester.
  - Counters reset to 0 and increment on each accepted handshake.
  - Counters stick at 0xFFFFFFFF.
- Macro undefined: the port and counters are absent, and behaviour is otherwise identical.

## Structure
- Package mult_arb_pkg holds:
  - MULT_LATENCY = 2
  - PERF_CNT_W = 32
  - function id_width(n) returning $clog2(n), minimum 1
  - the tag struct typedef {valid, id}
- Sub-module pipelined_multiplier_2stage (INPUT_WIDTH passed through) provides the datapath. The arbiter, tag pipe and response demux live in mult_rr_arbiter.

## Test plan
- Reset, then requester 2 alone with A=3, B=-5: ready[2] same cycle; 2 cycles later o_rsp_valid=4'b0100 and o_rsp_data=-15.
- All 4 requesters valid for 8 cycles: grant order 0,1,2,3,0,1,2,3. Responses follow the same order at +2 cycles with correct products.
- rr_ptr=2 with valid from requesters 0 and 3: requester 3 granted first, then 0.
- Extremes: A=B=-131072 gives 17179869184; A=131071, B=-131072 gives -17179738112.
- Assert i_reset one cycle after two grants: no o_rsp_valid follows, and o_busy=0 the cycle after reset.
- With MULT_ARB_PERF_CNT_EN: 5 accepts on requester 1 give o_grant_cnt[63:32]=5. A counter preloaded by force to 0xFFFFFFFE stays at 0xFFFFFFFF after 3 accepts.
